// File: rtl/prbs_checker.sv
// Serial PRBS checker for the x^32+x^30+x^26+x^25 LFSR stream: self-synchronizes
// from received history, then flags, counts and tracks loss of sync on mispredictions.
module prbs_checker #(
  parameter int unsigned LOCK_COUNT = 64,
  parameter int unsigned LOSS_COUNT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_counts,
  input  logic        in_valid,
  input  logic        in_bit,
  output logic        locked,
  output logic        err_pulse,
  output logic        sync_lost,
  output logic [15:0] err_count
);

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [7:0] LOCK_TGT = 8'(LOCK_COUNT);
  localparam logic [7:0] LOSS_TGT = 8'(LOSS_COUNT);

  logic [1:0]  state;
  logic [31:0] hist;
  logic [4:0]  fill_cnt;
  logic [7:0]  match_cnt;
  logic [7:0]  miss_cnt;

  logic        pred;
  logic        match;
  logic [31:0] hist_next;
  logic [7:0]  match_inc;
  logic [7:0]  miss_inc;
  logic        count_err;

  always_comb begin
    pred      = hist[31] ^ hist[29] ^ hist[25] ^ hist[24];
    match     = (in_bit == pred);
    hist_next = {hist[30:0], in_bit};
    match_inc = match_cnt + 8'd1;
    miss_inc  = miss_cnt + 8'd1;
    count_err = in_valid && (state == LOCKED) && !match;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      hist      <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      sync_lost <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      sync_lost <= 1'b0;
      if (in_valid) begin
        hist <= hist_next;
        case (state)
          FILL: begin
            fill_cnt <= fill_cnt + 5'd1;
            if (fill_cnt == 5'd31) begin
              state     <= VERIFY;
              match_cnt <= '0;
            end
          end
          VERIFY: begin
            // An all-zero history trivially predicts zeros, so it never counts toward lock
            if (match && (hist != '0)) begin
              match_cnt <= match_inc;
              if (match_inc == LOCK_TGT) begin
                state    <= LOCKED;
                miss_cnt <= '0;
                locked   <= 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            if (!match) begin
              err_pulse <= 1'b1;
              miss_cnt  <= miss_inc;
            end else begin
              miss_cnt <= '0;
            end
            if ((!match && (miss_inc == LOSS_TGT)) || (hist_next == '0)) begin
              state     <= VERIFY;
              match_cnt <= '0;
              locked    <= 1'b0;
              sync_lost <= 1'b1;
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (clear_counts) begin
      err_count <= '0;
    end else if (count_err && (err_count != '1)) begin
      err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: clean lock, error multiplication, slip/relock,
// all-zero input, gapped input and err_count saturation/clear/reset rules.
module tb_prbs_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear_counts;
  logic        in_valid;
  logic        in_bit;
  logic        locked;
  logic        err_pulse;
  logic        sync_lost;
  logic [15:0] err_count;

  prbs_checker #(.LOCK_COUNT(64), .LOSS_COUNT(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .clear_counts (clear_counts),
    .in_valid     (in_valid),
    .in_bit       (in_bit),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .sync_lost    (sync_lost),
    .err_count    (err_count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [31:0] seed_v = 32'h8EAF696C;
  logic [31:0] gen;
  int          gen_n;
  logic        b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task gen_reset();
    gen   = '0;
    gen_n = 0;
  endtask

  // Transmitter model: seed bits MSB first, then the LFSR recurrence
  task gen_bit(output logic o);
    if (gen_n < 32) o = seed_v[31 - gen_n];
    else            o = gen[31] ^ gen[29] ^ gen[25] ^ gen[24];
    gen = {gen[30:0], o};
    gen_n++;
  endtask

  task step(input logic v, input logic d, input logic clr = 1'b0);
    @(negedge clock);
    in_valid     = v;
    in_bit       = d;
    clear_counts = clr;
    @(posedge clock);
    #1;
  endtask

  task do_reset();
    @(negedge clock);
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_bit       = 1'b0;
    clear_counts = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    gen_reset();
  endtask

  int pulses;
  int sl_cnt;
  int lock_cnt;
  int first_loss;
  int nv;
  int ep_idx[$];
  int exp_idx[5] = '{500, 525, 526, 530, 532};

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear_counts = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_locked", locked, 0);
    chk("reset_err_pulse", err_pulse, 0);
    chk("reset_sync_lost", sync_lost, 0);
    chk("reset_err_count", err_count, 0);
    reset = 1'b0;
    gen_reset();

    // Clean stream: lock on bit 96, then 10,000 bits without errors
    pulses = 0;
    for (int i = 0; i < 10000; i++) begin
      gen_bit(b);
      step(1'b1, b);
      if (i < 100) chk("clean_lock", locked, (i >= 95));
      pulses += int'(err_pulse) + int'(sync_lost);
    end
    chk("clean_err_count", err_count, 0);
    chk("clean_pulses", pulses, 0);
    chk("clean_locked", locked, 1);

    // Single flipped bit at index 500 -> five mispredictions
    do_reset();
    sl_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      gen_bit(b);
      step(1'b1, (i == 500) ? ~b : b);
      if (err_pulse) ep_idx.push_back(i);
      sl_cnt += int'(sync_lost);
    end
    chk("single_pulse_count", ep_idx.size(), 5);
    for (int k = 0; k < 5; k++)
      chk("single_pulse_idx", (k < ep_idx.size()) ? ep_idx[k] : -1, exp_idx[k]);
    chk("single_err_count", err_count, 5);
    chk("single_locked", locked, 1);
    chk("single_no_sync_lost", sl_cnt, 0);

    // Complemented stream mispredicts every bit: loss on the 8th
    for (int k = 0; k < 8; k++) begin
      gen_bit(b);
      step(1'b1, ~b);
      chk("slip_err_pulse", err_pulse, 1);
      chk("slip_sync_lost", sync_lost, (k == 7));
      chk("slip_locked", locked, (k < 7));
    end
    chk("slip_err_count", err_count, 13);
    for (int j = 0; j < 96; j++) begin
      gen_bit(b);
      step(1'b1, b);
      chk("relock", locked, (j >= 95));
    end

    // All-zero stream must never lock
    do_reset();
    lock_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 1'b0);
      lock_cnt += int'(locked);
    end
    chk("zero_never_locks", lock_cnt, 0);

    // Zeros while locked: sync lost by the 32nd zero
    do_reset();
    for (int i = 0; i < 96; i++) begin
      gen_bit(b);
      step(1'b1, b);
    end
    chk("zero_pre_locked", locked, 1);
    first_loss = -1;
    for (int z = 0; z < 32; z++) begin
      step(1'b1, 1'b0);
      if (sync_lost && first_loss < 0) first_loss = z;
    end
    chk("zero_sync_lost_seen", (first_loss >= 0), 1);
    chk("zero_unlocked", locked, 0);

    // Gapped input: valid on even cycles only
    do_reset();
    nv = 0;
    pulses = 0;
    for (int c = 0; c < 192; c++) begin
      if (c % 2 == 0) begin
        gen_bit(b);
        step(1'b1, b);
        nv++;
      end else begin
        step(1'b0, 1'b1);
        pulses += int'(err_pulse) + int'(sync_lost);
      end
      chk("gap_lock", locked, (nv >= 96));
    end
    chk("gap_no_pulses", pulses, 0);

    // Saturation, clear priority, asynchronous reset
    @(negedge clock);
    force dut.err_count = 16'hFFFF;
    #1;
    release dut.err_count;
    chk("sat_preload", err_count, 16'hFFFF);
    gen_bit(b);
    step(1'b1, ~b);
    chk("sat_err_pulse", err_pulse, 1);
    chk("sat_hold", err_count, 16'hFFFF);
    gen_bit(b);
    step(1'b1, ~b, 1'b1);
    chk("clear_err_pulse", err_pulse, 1);
    chk("clear_priority", err_count, 0);
    gen_bit(b);
    step(1'b1, ~b);
    chk("post_clear_count", err_count, 1);
    chk("pre_reset_locked", locked, 1);
    chk("pre_reset_pulse", err_pulse, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("async_locked", locked, 0);
    chk("async_err_pulse", err_pulse, 0);
    chk("async_sync_lost", sync_lost, 0);
    chk("async_err_count", err_count, 0);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial PRBS checker, the receive-side counterpart to the design's 32-bit LFSR random source. It consumes a stream of 1-bit samples, self-synchronizes to the LFSR sequence, and asserts `locked` once the stream is consistently predictable. While locked it flags every bit that disagrees with the prediction, counts those errors and detects loss of sync. It is used on board-level loopback and for in-system checks of the random source's output stream.

## Interface
- `LOCK_COUNT`, default 64: consecutive correct predictions required to declare lock (range 1..255).
- `LOSS_COUNT`, default 8: consecutive mispredictions while locked that declare loss of sync (range 1..255).
- `clock`, input, 1: system clock, rising-edge.
- `reset`, input, 1: asynchronous, active-high.
- `clear_counts`, input, 1: synchronous clear of `err_count`.
- `in_valid`, input, 1: `in_bit` is a valid sample this cycle.
- `in_bit`, input, 1: received sequence bit.
- `locked`, output, 1: checker is synchronized.
- `err_pulse`, output, 1: one-cycle flag for a mispredicted bit while locked.
- `sync_lost`, output, 1: one-cycle flag on the LOCKED→VERIFY transition.
- `err_count`, output, 16: saturating count of mispredicted bits while locked.

## Operation
- **Sequence definition:** b[n] = b[n-32] ^ b[n-30] ^ b[n-26] ^ b[n-25].
- **History register:** `hist[31:0]`, where `hist[0]` is the newest accepted bit.
  - On every `in_valid` cycle, in every state: `hist <= {hist[30:0], in_bit}`.
  - Prediction: `pred = hist[31]^hist[29]^hist[25]^hist[24]`, evaluated before the shift.
  - `match = (in_bit == pred)`.
- Cycles with `in_valid = 0` change nothing: no shift, no counter change, no state change, and no pulses.
- **State machine** (states FILL, VERIFY, LOCKED):
  - **FILL:**
    - `fill_cnt` counts accepted bits, 0..31.
    - On the 32nd accepted bit, go to VERIFY with `match_cnt = 0`.
    - No comparisons are made in FILL.
  - **VERIFY:**
    - On a match with `hist != 0`: increment `match_cnt`.
    - On a mismatch: `match_cnt <= 0`. The checker self-synchronizes because history is always built from received data, so there is no refill.
    - On a match with `hist == 0`: `match_cnt <= 0`. An all-zero stream must never lock.
    - When the increment makes `match_cnt == LOCK_COUNT`, go to LOCKED with `miss_cnt = 0`.
  - **LOCKED:**
    - On a mismatch: `err_pulse = 1`, `err_count` increments (saturating at 16'hFFFF), `miss_cnt` increments.
    - On a match: `miss_cnt <= 0`.
    - If `miss_cnt` reaches `LOSS_COUNT`, go to VERIFY with `match_cnt = 0` and pulse `sync_lost`. The mismatch that triggers the transition is itself counted in `err_count`.
    - If the post-shift history becomes 32'h0, go to VERIFY and pulse `sync_lost`. This is the all-zero lockup.
- **Error multiplication:** one flipped input bit produces 5 mispredictions: at n, n+25, n+26, n+30 and n+32. This is expected behaviour and is not corrected.
- **`err_count` rules:**
  - Increments only in LOCKED.
  - `clear_counts` takes priority over a same-cycle increment; the result is 0.
  - Once saturated, stays at 16'hFFFF until cleared or reset.
- **Widths:** `fill_cnt` 5 bits; `match_cnt` and `miss_cnt` 8 bits each.

## Timing
- **Reset values** (applied asynchronously):
  - State FILL; `hist`, `fill_cnt`, `match_cnt` and `miss_cnt` all 0.
  - `locked = 0`, `err_pulse = 0`, `sync_lost = 0`, `err_count = 0`.
- All outputs are registered.
  - `err_pulse` and `sync_lost` are high for exactly the one cycle after the clock edge that accepted the offending bit.
  - `locked` rises on the edge that accepts the LOCK_COUNT-th counted match, and falls on the edge that leaves LOCKED.
- **Latency:** from reset release, a clean stream locks after 32 + LOCK_COUNT valid bits (96 with defaults), regardless of `in_valid` gaps.
- **Reset mid-operation:** everything returns to the reset values immediately, including `err_count`. A pending pulse is dropped.
- `err_pulse` and `sync_lost` may be high in the same cycle; both are high on the loss-triggering mismatch.

## Test plan
- **Clean stream:** feed a correct stream whose first 32 bits are seed 32'h8EAF696C (first bit in = `hist[31]`), with `in_valid` held high. Required: `locked` rises after exactly 96 bits; `err_count` stays 0 for 10,000 bits.
- **Single bit error:** same stream, flip one bit at index 500 after lock. Required: exactly 5 `err_pulse`s, at indices 500, 525, 526, 530 and 532; `err_count = 5`; `locked` stays 1; no `sync_lost`.
- **Sequence slip and relock:** while locked, switch to random non-PRBS data. Required: `sync_lost` pulses within the first run of 8 consecutive misses, `locked` falls, and the checker relocks 96 bits after the correct PRBS resumes (32 to flush the history + 64 matches).
- **All-zero stream:** all-zero input from reset. Required: `locked` never rises within 1,000 bits. Zero input while locked → `sync_lost` by the 32nd zero.
- **Gapped input:** clean stream with `in_valid` toggling 1-0-1-0. Required: lock after 96 valid bits (192 cycles); no pulses on invalid cycles.
- **Counter rules:** force `err_count` to 16'hFFFF, inject an error → stays 16'hFFFF. `clear_counts` coincident with an error → 0. Assert `reset` mid-lock → all outputs 0 in the same cycle.
